control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Upstream sequencer for the 4x8 register file, ALU and internal 8-bit databus.
- Fetches 8-bit instructions over a req/ack port and decodes them.
- Steps a small FSM that drives register-file load/enable/select lines, ALU control, and its own immediate driver onto the shared databus.
- The only source of bus-enable sequencing in the CPU.

Parameters:
- RESET_PC, 8'h00, program counter value loaded on reset.

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state on the next rising edge
instr_req  output  1  instruction/immediate fetch request
instr_addr  output  8  fetch address (equals pc)
instr_ack  input  1  fetch complete; instr_data valid this cycle
instr_data  input  8  fetched byte
databus  inout  8  shared bus; driven with the immediate when imm_enable=1, else 8'hzz
reg_load  output  1  register file load strobe
reg_enable  output  1  register file drives databus
in_regselect  output  2  destination register
out_regselect  output  2  register driven onto databus
alu_regselect  output  2  register routed to the ALU B operand
alu_latch  output  1  ALU captures databus as operand A
alu_drive  output  1  ALU drives its result onto databus
alu_op  output  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
flags_update  output  1  ALU updates zero/carry flags
zero_flag  input  1  ALU zero flag
carry_flag  input  1  ALU carry flag
halted  output  1  high in HALT state

Behaviour:
- Instruction byte layout: [7:4] opcode, [3:2] rd, [1:0] rs.
- Opcodes: 0 NOP; 1 MOV rd,rs; 2 LDI rd,#imm; 3-7 ADD/SUB/AND/OR/XOR rd,rs (alu_op = opcode-3); 8 JMP #imm; 9 JZ #imm; A JC #imm; F HLT; B-E undefined, executed as NOP.
- Internal registers: pc (8b), ir (8b), imm (8b), state.
- Reset: state=FETCH, pc=RESET_PC, ir=0, imm=0. All strobes/enables/halted low; databus released; selects 0. A reset asserted in any state, including mid-fetch, takes effect on the next edge; no partial register write completes after that edge.
- Outputs are combinational functions of registered state/ir only, never of the ack inputs. Any output not listed for a state is 0.
- FETCH: instr_req=1, instr_addr=pc. Waits indefinitely with address stable. On ack: ir<=instr_data, pc<=pc+1 (255 wraps to 0), go DECODE.
- DECODE (1 cycle, no strobes):
  - NOP/undefined -> FETCH.
  - MOV and ALU ops -> EXEC1.
  - LDI/JMP/JZ/JC -> FETCH_IMM.
  - HLT -> HALT.
- FETCH_IMM: same handshake as FETCH; on ack imm<=instr_data, pc<=pc+1, go EXEC1.
- EXEC1:
  - MOV: reg_enable=1, out_regselect=rs, reg_load=1, in_regselect=rd -> FETCH. MOV rd,rd is legal.
  - LDI: imm_enable (internal)=1, databus=imm, reg_load=1, in_regselect=rd -> FETCH.
  - JMP: pc<=imm -> FETCH.
  - JZ/JC: pc<=imm if zero_flag/carry_flag (sampled this cycle) is 1, else pc unchanged -> FETCH.
  - ALU op: reg_enable=1, out_regselect=rs, alu_latch=1 -> EXEC2.
- EXEC2 (ALU ops only): alu_regselect=rd, alu_op valid, alu_drive=1, reg_load=1, in_regselect=rd, flags_update=1 -> FETCH.
- HALT: instr_req=0, halted=1; leaves only on reset.
- Instruction latency in cycles, excluding ack wait:
  - NOP: 2
  - MOV: 3
  - JMP/JZ/JC: 4
  - LDI: 4
  - ALU ops: 4
- Bus exclusivity invariant: at most one of reg_enable, imm_enable, alu_drive is high in any cycle.
- Immediate fetch at pc=255 reads address 255; pc then wraps to 0.

Decomposition:
- Shared package cpu_pkg: opcode constants, alu_op encoding, FSM state enum (FETCH, DECODE, FETCH_IMM, EXEC1, EXEC2, HALT), instruction field positions.
- One sub-module, instr_decoder: combinational map from ir to {instruction class, alu_op, rd, rs, needs_imm}.
- The FSM, pc, and databus driver stay in control_unit.

Test Plan:
- Reset then program {8'h24, 8'h5A}, ack after 0 and 3 wait cycles -> instr_addr 0 then 1, held stable while waiting; EXEC1 shows databus=8'h5A, reg_load=1, in_regselect=1; pc=2.
- ADD r2,r1 (8'h39) -> EXEC1: reg_enable=1, out_regselect=1, alu_latch=1. Next cycle: alu_drive=1, alu_regselect=2, in_regselect=2, alu_op=0, flags_update=1. No cycle has two bus drivers.
- JZ #8'h40 (8'h90,8'h40): with zero_flag=1 -> next instr_addr 8'h40; with zero_flag=0 -> next instr_addr = jump address+2.
- pc=8'hFF fetching NOP -> next instr_addr 8'h00; undefined 8'hC3 -> behaves as NOP, no strobes asserted.
- HLT 8'hF0 -> halted=1, instr_req=0 indefinitely; reset -> pc=RESET_PC, FETCH on the next edge.
- Reset asserted during EXEC2 of SUB -> no reg_load on the following cycle; state=FETCH, all outputs 0 except instr_req.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, ALU encoding, instruction fields and FSM states shared by the control unit
package cpu_pkg;
  localparam int OPC_HI = 7;
  localparam int OPC_LO = 4;
  localparam int RD_HI = 3;
  localparam int RD_LO = 2;
  localparam int RS_HI = 1;
  localparam int RS_LO = 0;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_LDI = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ = 4'h9;
  localparam logic [3:0] OP_JC = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_FETCH_IMM, S_EXEC1, S_EXEC2, S_HALT} state_e;
  typedef enum logic [2:0] {C_NOP, C_MOV, C_LDI, C_JMP, C_JZ, C_JC, C_ALU, C_HLT} iclass_e;
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational split of the instruction register into class, ALU op and register fields
// ports: ir_i instruction byte; cls_o iclass_e value; alu_op_o ALU function; rd_o/rs_o register fields;
//        needs_imm_o instruction carries a trailing immediate byte
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [7:0] ir_i,
  output logic [2:0] cls_o,
  output logic [2:0] alu_op_o,
  output logic [1:0] rd_o,
  output logic [1:0] rs_o,
  output logic       needs_imm_o
);
  always_comb begin
    cls_o = C_NOP;
    alu_op_o = ALU_ADD;
    case (ir_i[OPC_HI:OPC_LO])
      OP_MOV: cls_o = C_MOV;
      OP_LDI: cls_o = C_LDI;
      OP_ADD: begin cls_o = C_ALU; alu_op_o = ALU_ADD; end
      OP_SUB: begin cls_o = C_ALU; alu_op_o = ALU_SUB; end
      OP_AND: begin cls_o = C_ALU; alu_op_o = ALU_AND; end
      OP_OR:  begin cls_o = C_ALU; alu_op_o = ALU_OR; end
      OP_XOR: begin cls_o = C_ALU; alu_op_o = ALU_XOR; end
      OP_JMP: cls_o = C_JMP;
      OP_JZ:  cls_o = C_JZ;
      OP_JC:  cls_o = C_JC;
      OP_HLT: cls_o = C_HLT;
      default: cls_o = C_NOP;
    endcase
  end
  assign rd_o = ir_i[RD_HI:RD_LO];
  assign rs_o = ir_i[RS_HI:RS_LO];
  assign needs_imm_o = cls_o == C_LDI || cls_o == C_JMP || cls_o == C_JZ || cls_o == C_JC;
endmodule

// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer driving register file, ALU and databus enables
// ports: clock/reset (sync, active-high); instr_req/instr_addr/instr_ack/instr_data fetch port;
//        databus shared bus (immediate driver); reg_* register file controls; alu_* ALU controls;
//        flags_update, zero_flag/carry_flag ALU flags; halted high in HALT
module control_unit
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  output logic       instr_req,
  output logic [7:0] instr_addr,
  input  logic       instr_ack,
  input  logic [7:0] instr_data,
  inout  wire  [7:0] databus,
  output logic       reg_load,
  output logic       reg_enable,
  output logic [1:0] in_regselect,
  output logic [1:0] out_regselect,
  output logic [1:0] alu_regselect,
  output logic       alu_latch,
  output logic       alu_drive,
  output logic [2:0] alu_op,
  output logic       flags_update,
  input  logic       zero_flag,
  input  logic       carry_flag,
  output logic       halted
);
  state_e     state_q;
  logic [7:0] pc_q;
  logic [7:0] ir_q;
  logic [7:0] imm_q;
  logic [2:0] cls;
  logic [2:0] dec_op;
  logic [1:0] rd;
  logic [1:0] rs;
  logic       needs_imm;
  logic       e1;
  logic       e2;
  logic       imm_en;
  instr_decoder u_dec (
    .ir_i       (ir_q),
    .cls_o      (cls),
    .alu_op_o   (dec_op),
    .rd_o       (rd),
    .rs_o       (rs),
    .needs_imm_o(needs_imm)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q <= RESET_PC;
      ir_q <= 8'h00;
      imm_q <= 8'h00;
    end else begin
      case (state_q)
        S_FETCH: if (instr_ack) begin
          ir_q <= instr_data;
          pc_q <= pc_q + 8'd1;
          state_q <= S_DECODE;
        end
        S_DECODE: state_q <= cls == C_HLT ? S_HALT : cls == C_NOP ? S_FETCH : needs_imm ? S_FETCH_IMM : S_EXEC1;
        S_FETCH_IMM: if (instr_ack) begin
          imm_q <= instr_data;
          pc_q <= pc_q + 8'd1;
          state_q <= S_EXEC1;
        end
        S_EXEC1: begin
          if (cls == C_JMP || (cls == C_JZ && zero_flag) || (cls == C_JC && carry_flag)) pc_q <= imm_q;
          state_q <= cls == C_ALU ? S_EXEC2 : S_FETCH;
        end
        S_EXEC2: state_q <= S_FETCH;
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end
  // EXEC2 is only reachable from an ALU instruction, so it needs no class qualification
  always_comb begin
    e1 = state_q == S_EXEC1;
    e2 = state_q == S_EXEC2;
    imm_en = e1 && cls == C_LDI;
    instr_req = state_q == S_FETCH || state_q == S_FETCH_IMM;
    reg_enable = e1 && (cls == C_MOV || cls == C_ALU);
    reg_load = (e1 && (cls == C_MOV || cls == C_LDI)) || e2;
    in_regselect = reg_load ? rd : 2'd0;
    out_regselect = reg_enable ? rs : 2'd0;
    alu_latch = e1 && cls == C_ALU;
    alu_drive = e2;
    alu_regselect = e2 ? rd : 2'd0;
    alu_op = e2 ? dec_op : 3'd0;
    flags_update = e2;
    halted = state_q == S_HALT;
  end
  assign instr_addr = pc_q;
  assign databus = imm_en ? imm_q : 8'hzz;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: ISA-level reference model feeding a scoreboard of fetches and register writes
module tb_control_unit;
  localparam logic [7:0] RST_PC = 8'h00;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       instr_ack = 1'b0;
  logic [7:0] instr_data = 8'h00;
  logic       zero_flag = 1'b0;
  logic       carry_flag = 1'b0;
  logic       instr_req;
  logic [7:0] instr_addr;
  wire  [7:0] databus;
  logic       reg_load;
  logic       reg_enable;
  logic [1:0] in_regselect;
  logic [1:0] out_regselect;
  logic [1:0] alu_regselect;
  logic       alu_latch;
  logic       alu_drive;
  logic [2:0] alu_op;
  logic       flags_update;
  logic       halted;

  typedef struct packed {logic [7:0] addr; logic [3:0] gap;} fetch_t;
  typedef struct packed {logic [1:0] kind; logic [1:0] rd; logic [1:0] rs; logic [1:0] asel; logic fu; logic [7:0] data; logic [2:0] op;} wr_t;

  fetch_t     fq[$];
  wr_t        wq[$];
  logic [7:0] mem[256];
  int         checks = 0;
  int         errors = 0;
  int         budget = 0;
  bit         halt_exp;

  always #5 clock = ~clock;

  control_unit #(.RESET_PC(RST_PC)) dut (
    .clock(clock), .reset(reset), .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_ack(instr_ack), .instr_data(instr_data), .databus(databus), .reg_load(reg_load),
    .reg_enable(reg_enable), .in_regselect(in_regselect), .out_regselect(out_regselect),
    .alu_regselect(alu_regselect), .alu_latch(alu_latch), .alu_drive(alu_drive), .alu_op(alu_op),
    .flags_update(flags_update), .zero_flag(zero_flag), .carry_flag(carry_flag), .halted(halted)
  );

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string name);
    check(name, int'({instr_req, instr_addr, reg_load, reg_enable, in_regselect, out_regselect, alu_regselect,
                      alu_latch, alu_drive, alu_op, flags_update, halted}), int'({1'b1, RST_PC, 15'd0}));
  endtask

  function automatic wr_t mk(input logic [1:0] kind, input logic [1:0] rd, input logic [1:0] rs,
                             input logic [7:0] data, input logic [2:0] op);
    wr_t w;
    w.kind = kind; w.rd = rd; w.rs = rs; w.asel = kind == 2'd3 ? rd : 2'd0;
    w.fu = kind == 2'd3; w.data = data; w.op = op;
    return w;
  endfunction

  // Memory slave: random 0-3 cycle ack latency, stops acking once the model's fetch budget is spent
  task automatic responder();
    int done = 0;
    int wl = 0;
    forever begin
      @(posedge clock);
      #2;
      if (reset) begin
        done = 0;
        instr_ack = 1'b0;
      end else if (instr_req && done < budget) begin
        if (wl == 0) begin
          instr_ack = 1'b1;
          instr_data = mem[instr_addr];
          done++;
          wl = $urandom_range(0, 3);
        end else begin
          instr_ack = 1'b0;
          wl--;
        end
      end else instr_ack = 1'b0;
    end
  endtask

  task automatic monitor();
    int gap = 0;
    logic [1:0] lrs = 2'd0;
    fetch_t f;
    wr_t w;
    wr_t o;
    forever begin
      @(negedge clock);
      if (!reset) begin
        check("bus_excl", int'(reg_enable && alu_drive), 0);
        if (!(instr_req && !instr_ack)) gap++;
        if (instr_req && instr_ack) begin
          if (fq.size() == 0) check("fetch_unexpected", 1, 0);
          else begin
            f = fq.pop_front();
            check("fetch_addr", int'(instr_addr), int'(f.addr));
            if (f.gap != 0) check("fetch_gap", gap, int'(f.gap));
          end
          gap = 0;
        end
        if (alu_latch) begin
          check("latch_cycle", int'({reg_enable, reg_load, alu_drive}), 3'b100);
          lrs = out_regselect;
        end
        if (reg_load) begin
          o.kind = reg_enable ? 2'd1 : alu_drive ? 2'd3 : 2'd2;
          o.rd = in_regselect;
          o.rs = reg_enable ? out_regselect : alu_drive ? lrs : 2'd0;
          o.asel = alu_regselect;
          o.fu = flags_update;
          o.data = o.kind == 2'd2 ? databus : 8'h00;
          o.op = alu_op;
          if (wq.size() == 0) check("write_unexpected", int'(o), 0);
          else begin
            w = wq.pop_front();
            check("write", int'(o), int'(w));
          end
        end
      end
    end
  endtask

  // Instruction-set interpreter: expected fetch addresses with non-wait cycle gaps, and register writes
  task automatic model(input int max_instr);
    logic [7:0] pc = RST_PC;
    logic [7:0] b;
    logic [7:0] imm;
    logic [3:0] op;
    int gap = 0;
    int nf = 0;
    fetch_t f;
    halt_exp = 0;
    for (int i = 0; i < max_instr; i++) begin
      b = mem[pc];
      f.addr = pc; f.gap = 4'(gap);
      fq.push_back(f);
      nf++;
      pc = pc + 8'd1;
      op = b[7:4];
      if (op == 4'h2 || op == 4'h8 || op == 4'h9 || op == 4'hA) begin
        f.addr = pc; f.gap = 4'd2;
        fq.push_back(f);
        nf++;
        imm = mem[pc];
        pc = pc + 8'd1;
        if (op == 4'h2) wq.push_back(mk(2'd2, b[3:2], 2'd0, imm, 3'd0));
        if (op == 4'h8 || (op == 4'h9 && zero_flag) || (op == 4'hA && carry_flag)) pc = imm;
        gap = 2;
      end else if (op == 4'h1) begin
        wq.push_back(mk(2'd1, b[3:2], b[1:0], 8'h00, 3'd0));
        gap = 3;
      end else if (op >= 4'h3 && op <= 4'h7) begin
        wq.push_back(mk(2'd3, b[3:2], b[1:0], 8'h00, 3'(op - 4'h3)));
        gap = 4;
      end else if (op == 4'hF) begin
        halt_exp = 1;
        break;
      end else gap = 2;
    end
    budget = nf;
  endtask

  task automatic run(input int max_instr, input bit zf, input bit cf);
    int t = 0;
    reset = 1'b1;
    zero_flag = zf;
    carry_flag = cf;
    fq.delete();
    wq.delete();
    model(max_instr);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    while ((fq.size() != 0 || wq.size() != 0) && t < 3000) begin
      @(negedge clock);
      #1;
      t++;
    end
    check("run_timeout", int'(t < 3000), 1);
    if (halt_exp) begin
      repeat (3) @(negedge clock);
      check("halted", int'({halted, instr_req}), 2'b10);
    end
  endtask

  task automatic fill();
    foreach (mem[i]) mem[i] = 8'hF0;
  endtask

  initial begin
    fork
      monitor();
      responder();
    join_none
    @(posedge clock);
    #1 check_idle("reset_state");
    fill(); mem[0] = 8'h24; mem[1] = 8'h5A;
    run(10, 0, 0);
    fill(); mem[0] = 8'h39; mem[1] = 8'h4E; mem[2] = 8'h53; mem[3] = 8'h6C; mem[4] = 8'h71;
    run(10, 0, 0);
    fill(); mem[0] = 8'h90; mem[1] = 8'h40;
    run(10, 1, 0);
    run(10, 0, 0);
    fill(); mem[0] = 8'hA0; mem[1] = 8'h40;
    run(10, 0, 1);
    fill(); mem[0] = 8'h15; mem[1] = 8'h1A; mem[2] = 8'h13;
    run(10, 0, 0);
    fill(); mem[0] = 8'h80; mem[1] = 8'hFF; mem[8'hFF] = 8'hC3;
    run(5, 0, 0);
    fill(); mem[0] = 8'h80; mem[1] = 8'hFE; mem[8'hFE] = 8'h2C; mem[8'hFF] = 8'h77;
    run(4, 0, 0);
    fill();
    run(10, 0, 0);
    repeat (20) @(negedge clock);
    check("halt_hold", int'({halted, instr_req}), 2'b10);
    reset = 1'b1;
    @(posedge clock);
    #1 check_idle("reset_from_halt");
    fill(); mem[0] = 8'h49;
    run(1, 0, 0);
    check("in_exec2", int'({alu_drive, reg_load}), 2'b11);
    reset = 1'b1;
    @(posedge clock);
    #1 check_idle("reset_mid_exec2");
    for (int r = 0; r < 40; r++) begin
      foreach (mem[i]) mem[i] = 8'($urandom);
      run(30, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
